// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the shared RAM / external bus data port.
// Serves one transaction at a time; bus accesses wait for ack or time out with an error.
module mem_arbiter #(
  parameter int RAMAddrWidth = 10,
  parameter int DataWidth    = 32,
  parameter int BusTimeout   = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_m0_req,
  input  logic                    i_m0_we,
  input  logic [31:0]             i_m0_addr,
  input  logic [DataWidth-1:0]    i_m0_wdata,
  output logic                    o_m0_gnt,
  output logic                    o_m0_rvalid,
  output logic [DataWidth-1:0]    o_m0_rdata,
  output logic                    o_m0_err,
  input  logic                    i_m1_req,
  input  logic                    i_m1_we,
  input  logic [31:0]             i_m1_addr,
  input  logic [DataWidth-1:0]    i_m1_wdata,
  output logic                    o_m1_gnt,
  output logic                    o_m1_rvalid,
  output logic [DataWidth-1:0]    o_m1_rdata,
  output logic                    o_m1_err,
  output logic                    o_ram_we,
  output logic [RAMAddrWidth-1:0] o_ram_addr,
  output logic [DataWidth-1:0]    o_ram_wdata,
  input  logic [DataWidth-1:0]    i_ram_rdata,
  output logic                    o_bus_req,
  output logic                    o_bus_we,
  output logic [31:0]             o_bus_addr,
  output logic [DataWidth-1:0]    o_bus_wdata,
  input  logic [DataWidth-1:0]    i_bus_rdata,
  input  logic                    i_bus_ack
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUS_WAIT = 2'd1;
  localparam logic [1:0] RESP     = 2'd2;

  logic [1:0]           r_state;
  logic                 r_last1;
  logic                 r_owner1;
  logic                 r_we;
  logic                 r_isBus;
  logic                 r_err;
  logic [15:0]          r_cnt;
  logic [31:0]          r_busAddr;
  logic [DataWidth-1:0] r_busWdata;
  logic                 r_busWe;
  logic [DataWidth-1:0] r_busRdata;

  logic                 w_winner1;
  logic                 w_grant;
  logic                 w_grantRam;
  logic                 w_we;
  logic [31:0]          w_addr;
  logic [DataWidth-1:0] w_wdata;
  logic                 w_isBus;
  logic                 w_resp;
  logic [DataWidth-1:0] w_respData;

  // On a tie the master that was not granted last wins; grants are masked during reset.
  assign w_winner1  = i_m1_req & (~i_m0_req | ~r_last1);
  assign w_grant    = (i_m0_req | i_m1_req) & (r_state == IDLE) & ~i_rst;
  assign w_we       = w_winner1 ? i_m1_we    : i_m0_we;
  assign w_addr     = w_winner1 ? i_m1_addr  : i_m0_addr;
  assign w_wdata    = w_winner1 ? i_m1_wdata : i_m0_wdata;
  assign w_isBus    = |w_addr[31:RAMAddrWidth];
  assign w_grantRam = w_grant & ~w_isBus;

  assign o_m0_gnt    = w_grant & ~w_winner1;
  assign o_m1_gnt    = w_grant & w_winner1;
  assign o_ram_we    = w_grantRam & w_we;
  assign o_ram_addr  = w_grantRam ? w_addr[RAMAddrWidth-1:0] : '0;
  assign o_ram_wdata = (w_grantRam & w_we) ? w_wdata : '0;

  // Response source follows the registered region, so RAM data is only taken for RAM reads.
  assign w_resp      = (r_state == RESP);
  assign w_respData  = r_we ? '0 : (r_isBus ? r_busRdata : i_ram_rdata);
  assign o_m0_rvalid = w_resp & ~r_owner1;
  assign o_m1_rvalid = w_resp & r_owner1;
  assign o_m0_rdata  = o_m0_rvalid ? w_respData : '0;
  assign o_m1_rdata  = o_m1_rvalid ? w_respData : '0;
  assign o_m0_err    = o_m0_rvalid & r_err;
  assign o_m1_err    = o_m1_rvalid & r_err;

  assign o_bus_req   = (r_state == BUS_WAIT);
  assign o_bus_we    = o_bus_req & r_busWe;
  assign o_bus_addr  = r_busAddr;
  assign o_bus_wdata = r_busWdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_last1    <= 1'b1;
      r_owner1   <= 1'b0;
      r_we       <= 1'b0;
      r_isBus    <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
      r_busAddr  <= '0;
      r_busWdata <= '0;
      r_busWe    <= 1'b0;
      r_busRdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_last1    <= w_winner1;
            r_owner1   <= w_winner1;
            r_we       <= w_we;
            r_isBus    <= w_isBus;
            r_err      <= 1'b0;
            r_busRdata <= '0;
            if (w_isBus) begin
              r_busAddr  <= w_addr;
              r_busWdata <= w_wdata;
              r_busWe    <= w_we;
              r_cnt      <= '0;
              r_state    <= BUS_WAIT;
            end else begin
              r_state <= RESP;
            end
          end
        end
        BUS_WAIT: begin
          // r_cnt holds the number of completed wait cycles; ack wins over timeout in the last one.
          if (i_bus_ack) begin
            r_busRdata <= i_bus_rdata;
            r_err      <= 1'b0;
            r_state    <= RESP;
          end else if (r_cnt == 16'(BusTimeout - 1)) begin
            r_busRdata <= '0;
            r_err      <= 1'b1;
            r_state    <= RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a stimulus process queues expected responses at grant time,
// a monitor pops and compares on rvalid and checks arbitration, reset and bus-timing rules.
module tb_mem_arbiter;

  localparam int TimeoutCycles = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mReq [2];
  logic        mWe [2];
  logic [31:0] mAddr [2];
  logic [31:0] mWdata [2];
  logic        gnt [2];
  logic        rv [2];
  logic [31:0] rdata [2];
  logic        err [2];
  logic        ramWe;
  logic [9:0]  ramAddr;
  logic [31:0] ramWdata;
  logic [31:0] ramRdata;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [31:0] busRdataIn = '0;
  logic        busAck = 1'b0;

  logic [31:0] ramMem [1024];
  logic [31:0] refRam [1024];
  logic [31:0] busMem [logic [31:0]];
  logic [31:0] refBus [logic [31:0]];

  op_t         pend [2][$];
  op_t         cur [2];
  logic [32:0] expQ [2][$];

  int          nVec = 0;
  int          nMis = 0;
  bit          stimTimeout = 1'b0;
  int          sCnt = 0;

  mem_arbiter #(.RAMAddrWidth(10), .DataWidth(32), .BusTimeout(TimeoutCycles)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(mReq[0]), .i_m0_we(mWe[0]), .i_m0_addr(mAddr[0]), .i_m0_wdata(mWdata[0]),
    .o_m0_gnt(gnt[0]), .o_m0_rvalid(rv[0]), .o_m0_rdata(rdata[0]), .o_m0_err(err[0]),
    .i_m1_req(mReq[1]), .i_m1_we(mWe[1]), .i_m1_addr(mAddr[1]), .i_m1_wdata(mWdata[1]),
    .o_m1_gnt(gnt[1]), .o_m1_rvalid(rv[1]), .o_m1_rdata(rdata[1]), .o_m1_err(err[1]),
    .o_ram_we(ramWe), .o_ram_addr(ramAddr), .o_ram_wdata(ramWdata), .i_ram_rdata(ramRdata),
    .o_bus_req(busReq), .o_bus_we(busWe), .o_bus_addr(busAddr), .o_bus_wdata(busWdata),
    .i_bus_rdata(busRdataIn), .i_bus_ack(busAck)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] busPattern(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ramInit(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ramMem[i] = ramInit(i);
      refRam[i] = ramInit(i);
    end
  end

  always @(posedge clk) begin
    if (ramWe) ramMem[ramAddr] <= ramWdata;
    ramRdata <= ramMem[ramAddr];
  end

  // Bus slave: acks in the (addr[2:0]+1)-th request cycle, so low bits >= 4 never ack in time.
  always @(negedge clk) begin
    if (busReq) begin
      sCnt++;
      if (sCnt == int'(busAddr[2:0]) + 1) begin
        busAck = 1'b1;
        if (busWe) begin
          busMem[busAddr] = busWdata;
          busRdataIn = $urandom;
        end else begin
          busRdataIn = busMem.exists(busAddr) ? busMem[busAddr] : busPattern(busAddr);
        end
      end else begin
        busAck = 1'b0;
        busRdataIn = $urandom;
      end
    end else begin
      sCnt = 0;
      busAck = 1'b0;
      busRdataIn = $urandom;
    end
  end

  // Reference model: RAM is a word array, bus is a sparse memory; slow bus accesses error out.
  function automatic logic [32:0] refModel(input op_t op);
    if (op.addr < 32'h400) begin
      if (op.we) begin
        refRam[op.addr[9:0]] = op.wdata;
        return '0;
      end
      return {1'b0, refRam[op.addr[9:0]]};
    end
    if (int'(op.addr[2:0]) + 1 > TimeoutCycles) return {1'b1, 32'h0};
    if (op.we) begin
      refBus[op.addr] = op.wdata;
      return '0;
    end
    return {1'b0, refBus.exists(op.addr) ? refBus[op.addr] : busPattern(op.addr)};
  endfunction

  bit          lastPtr = 1'b1;
  bit          busy = 1'b0;
  bit          busyRam = 1'b0;
  int          owner = 0;
  int          sinceGnt = 0;
  int          busCnt = 0;
  logic [31:0] gntAddr = '0;
  bit          toReported = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      nVec++;
      if ({gnt[0], gnt[1], rv[0], rv[1], err[0], err[1], ramWe, busReq, busWe} != '0 ||
          rdata[0] != '0 || rdata[1] != '0 || ramAddr != '0 || ramWdata != '0 ||
          busAddr != '0 || busWdata != '0) begin
        nMis++;
        $display("[TB] FAIL resetOutputs: gnt=%b%b rvalid=%b%b ram_we=%b ram_addr=%h bus_req=%b bus_addr=%h, required all 0",
                 gnt[1], gnt[0], rv[1], rv[0], ramWe, ramAddr, busReq, busAddr);
      end
      lastPtr = 1'b1;
      busy = 1'b0;
      busCnt = 0;
    end else begin
      automatic bit wasBusy = busy;
      automatic int expLen;
      if (stimTimeout && !toReported) begin
        toReported = 1'b1;
        nVec++;
        nMis++;
        $display("[TB] FAIL drainTimeout: stimulus did not complete within its cycle budget");
      end
      if (busy) sinceGnt++;
      if (rv[0] && rv[1]) begin
        nVec++;
        nMis++;
        $display("[TB] FAIL dualRvalid: rvalid=%b%b, required at most one", rv[1], rv[0]);
      end
      for (int m = 0; m < 2; m++) begin
        if (!rv[m] && (rdata[m] != '0 || err[m])) begin
          nVec++;
          nMis++;
          $display("[TB] FAIL idleOutputs m%0d: rdata=%h err=%b, required 0", m, rdata[m], err[m]);
        end
        if (rv[m]) begin
          nVec++;
          if (!busy || owner != m) begin
            nMis++;
            $display("[TB] FAIL rvalidOwner m%0d: owner=%0d busy=%b", m, owner, busy);
          end else if (busyRam && sinceGnt != 1) begin
            nMis++;
            $display("[TB] FAIL ramLatency m%0d: rvalid %0d cycles after gnt, required 1", m, sinceGnt);
          end
          if (expQ[m].size() == 0) begin
            nMis++;
            $display("[TB] FAIL unexpectedRvalid m%0d: got err=%b rdata=%h, required no response", m, err[m], rdata[m]);
          end else begin
            automatic logic [32:0] e = expQ[m].pop_front();
            if ({err[m], rdata[m]} != e) begin
              nMis++;
              $display("[TB] FAIL resp m%0d: got err=%b rdata=%h, required err=%b rdata=%h",
                       m, err[m], rdata[m], e[32], e[31:0]);
            end
          end
          busy = 1'b0;
        end
      end
      if (gnt[0] || gnt[1]) begin
        nVec++;
        if (gnt[0] && gnt[1]) begin
          nMis++;
          $display("[TB] FAIL dualGnt: gnt=11, required at most one");
        end else begin
          automatic int w = gnt[1] ? 1 : 0;
          if (!mReq[w]) begin
            nMis++;
            $display("[TB] FAIL gntNoReq: gnt to m%0d with req low", w);
          end else if (mReq[0] && mReq[1] && w == int'(lastPtr)) begin
            nMis++;
            $display("[TB] FAIL arbitration: got gnt m%0d, required m%0d", w, 1 - w);
          end else if (wasBusy) begin
            nMis++;
            $display("[TB] FAIL gntWhileBusy: gnt m%0d while m%0d transaction outstanding", w, owner);
          end
          lastPtr = w[0];
          owner = w;
          busy = 1'b1;
          sinceGnt = 0;
          gntAddr = mAddr[w];
          busyRam = (mAddr[w] < 32'h400);
        end
      end
      if (busReq) begin
        busCnt++;
      end else if (busCnt > 0) begin
        expLen = int'(gntAddr[2:0]) + 1;
        if (expLen > TimeoutCycles) expLen = TimeoutCycles;
        nVec++;
        if (busCnt != expLen) begin
          nMis++;
          $display("[TB] FAIL busReqLength: got %0d cycles, required %0d", busCnt, expLen);
        end
        busCnt = 0;
      end
    end
  end

  task automatic applyStimulus(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    op_t op;
    op.we = we;
    op.addr = addr;
    op.wdata = wdata;
    pend[m].push_back(op);
  endtask

  // Requests are raised after a posedge and grants observed at the following negedge.
  task automatic runOps(input int raisePct, input int dropPct, input int maxCycles);
    int cyc = 0;
    bit granted [2] = '{1'b0, 1'b0};
    while ((pend[0].size() != 0 || pend[1].size() != 0 || mReq[0] || mReq[1] ||
            expQ[0].size() != 0 || expQ[1].size() != 0) && cyc < maxCycles) begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
        if (granted[m]) begin
          mReq[m] = 1'b0;
          granted[m] = 1'b0;
        end else if (mReq[m] && $urandom_range(99) < dropPct) begin
          mReq[m] = 1'b0;
          pend[m].push_front(cur[m]);
        end else if (!mReq[m] && pend[m].size() != 0 && $urandom_range(99) < raisePct) begin
          cur[m] = pend[m].pop_front();
          mWe[m] = cur[m].we;
          mAddr[m] = cur[m].addr;
          mWdata[m] = cur[m].wdata;
          mReq[m] = 1'b1;
        end
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (mReq[m] && gnt[m]) begin
          granted[m] = 1'b1;
          expQ[m].push_back(refModel(cur[m]));
        end
      end
      cyc++;
    end
    if (cyc >= maxCycles) stimTimeout = 1'b1;
  endtask

  task automatic checkOutput();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  endtask

  initial begin
    int n;
    for (int m = 0; m < 2; m++) begin
      mReq[m] = 1'b1;
      mWe[m] = 1'b1;
      mAddr[m] = 32'h5 + 32'(m);
      mWdata[m] = 32'hFFFF_FFFF;
    end
    repeat (3) @(posedge clk);
    #1;
    mReq[0] = 1'b0;
    mReq[1] = 1'b0;
    rst = 1'b0;

    applyStimulus(0, 1'b1, 32'h3, 32'hA5A5_A5A5);
    applyStimulus(0, 1'b0, 32'h3, 32'h0);
    applyStimulus(0, 1'b1, 32'h402, 32'h1234_5678);
    applyStimulus(0, 1'b0, 32'h402, 32'h0);
    runOps(100, 0, 200);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b0, 32'(i), 32'h0);
      applyStimulus(1, 1'b1, 32'h10 + 32'(i), $urandom);
    end
    runOps(100, 0, 200);

    applyStimulus(0, 1'b0, 32'h404, 32'h0);
    applyStimulus(0, 1'b1, 32'h3FF, 32'h0BAD_F00D);
    applyStimulus(0, 1'b0, 32'h3FF, 32'h0);
    applyStimulus(0, 1'b0, 32'h400, 32'h0);
    runOps(100, 0, 200);

    // Reset while the bus request is outstanding: the pending response must never appear.
    @(posedge clk);
    #1;
    mWe[0] = 1'b0;
    mAddr[0] = 32'h405;
    mWdata[0] = '0;
    mReq[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!gnt[0] && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) stimTimeout = 1'b1;
    @(posedge clk);
    #1;
    mReq[0] = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(0, 1'b0, 32'h3, 32'h0);
    runOps(100, 0, 200);

    for (int i = 0; i < 150; i++) begin
      for (int m = 0; m < 2; m++) begin
        logic [31:0] a;
        case ($urandom_range(3))
          0:       a = 32'($urandom_range(15));
          1:       a = 32'h3F8 + 32'($urandom_range(15));
          2:       a = 32'h400 + 32'($urandom_range(63));
          default: a = $urandom;
        endcase
        applyStimulus(m, 1'($urandom_range(1)), a, $urandom);
      end
    end
    runOps(50, 10, 20000);

    checkOutput();
  end

endmodule
